// File: rtl/icache_tag_req_arbiter_if.sv
// icache_tag_req_arbiter_if: requester handshakes and tag-pipeline request bundle
interface icache_tag_req_arbiter_if #(
  parameter int PLD_WIDTH = 32,
  parameter int IDX_WIDTH = 3
);
  logic                 fetch_req_vld;
  logic                 fetch_req_rdy;
  logic [PLD_WIDTH-1:0] fetch_req_pld;
  logic                 pf_req_vld;
  logic                 pf_req_rdy;
  logic [PLD_WIDTH-1:0] pf_req_pld;
  logic                 snp_req_vld;
  logic                 snp_req_rdy;
  logic [PLD_WIDTH-1:0] snp_req_pld;
  logic                 tag_req_vld;
  logic                 tag_req_rdy;
  logic [PLD_WIDTH-1:0] tag_req_pld;
  logic [IDX_WIDTH-1:0] tag_req_index;
  logic [1:0]           tag_req_src;
  modport master (
    input  fetch_req_vld, fetch_req_pld, pf_req_vld, pf_req_pld, snp_req_vld, snp_req_pld, tag_req_rdy,
    output fetch_req_rdy, pf_req_rdy, snp_req_rdy, tag_req_vld, tag_req_pld, tag_req_index, tag_req_src
  );
  modport slave (
    output fetch_req_vld, fetch_req_pld, pf_req_vld, pf_req_pld, snp_req_vld, snp_req_pld, tag_req_rdy,
    input  fetch_req_rdy, pf_req_rdy, snp_req_rdy, tag_req_vld, tag_req_pld, tag_req_index, tag_req_src
  );
endinterface

// File: rtl/icache_tag_req_arbiter.sv
// icache_tag_req_arbiter: snoop/fetch/prefetch arbiter into the tag pipeline with MSHR index allocation
module icache_tag_req_arbiter #(
  parameter int MSHR_ENTRY_NUM         = 8,
  parameter int MSHR_ENTRY_INDEX_WIDTH = $clog2(MSHR_ENTRY_NUM),
  parameter int PF_STARVE_LIMIT        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  icache_tag_req_arbiter_if.master  bus,
  input  logic [MSHR_ENTRY_NUM-1:0] v_mshr_entry_array_valid,
  input  logic                      flush
);
  localparam int SW = $clog2(PF_STARVE_LIMIT + 1);
  logic [MSHR_ENTRY_NUM-1:0]         reserved;
  logic [MSHR_ENTRY_NUM-1:0]         free_mask;
  logic [MSHR_ENTRY_NUM-1:0]         grant_mask;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] alloc_idx;
  logic [SW-1:0]                     starve_cnt;
  logic slot_free, go, entry_avail, fetch_elig, pf_elig, pf_pri;
  logic snp_g, fetch_g, pf_g, any_g;
  assign free_mask   = ~v_mshr_entry_array_valid & ~reserved;
  assign entry_avail = |free_mask;
  always_comb begin
    alloc_idx = '0;
    for (int i = MSHR_ENTRY_NUM - 1; i >= 0; i--)
      if (free_mask[i]) alloc_idx = MSHR_ENTRY_INDEX_WIDTH'(i);
  end
  assign slot_free  = !bus.tag_req_vld || bus.tag_req_rdy;
  assign go         = slot_free && !flush;
  assign fetch_elig = bus.fetch_req_vld && entry_avail;
  assign pf_elig    = bus.pf_req_vld && entry_avail;
  assign pf_pri     = starve_cnt == SW'(PF_STARVE_LIMIT);
  assign snp_g      = go && bus.snp_req_vld;
  assign fetch_g    = go && !bus.snp_req_vld && fetch_elig && !(pf_pri && pf_elig);
  assign pf_g       = go && !bus.snp_req_vld && pf_elig && (pf_pri || !fetch_elig);
  assign any_g      = snp_g || fetch_g || pf_g;
  assign grant_mask = (fetch_g || pf_g) ? MSHR_ENTRY_NUM'(1) << alloc_idx : '0;
  assign bus.snp_req_rdy   = snp_g;
  assign bus.fetch_req_rdy = fetch_g;
  assign bus.pf_req_rdy    = pf_g;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tag_req_vld   <= 1'b0;
      bus.tag_req_pld   <= '0;
      bus.tag_req_index <= '0;
      bus.tag_req_src   <= '0;
      reserved          <= '0;
      starve_cnt        <= '0;
    end else if (flush) begin
      bus.tag_req_vld <= 1'b0;
      reserved        <= '0;
      starve_cnt      <= '0;
    end else begin
      reserved <= (reserved & ~v_mshr_entry_array_valid) | grant_mask;
      if (pf_g || !bus.pf_req_vld)
        starve_cnt <= '0;
      else if (pf_elig && slot_free && !pf_pri)
        starve_cnt <= starve_cnt + 1'b1;
      if (slot_free) begin
        bus.tag_req_vld <= any_g;
        if (any_g) begin
          bus.tag_req_pld   <= snp_g ? bus.snp_req_pld : pf_g ? bus.pf_req_pld : bus.fetch_req_pld;
          bus.tag_req_index <= snp_g ? '0 : alloc_idx;
          bus.tag_req_src   <= snp_g ? 2'd2 : pf_g ? 2'd1 : 2'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_tag_req_arbiter.sv
// tb_icache_tag_req_arbiter: directed vectors with a scoreboard checking every accepted tag request
module tb_icache_tag_req_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] valid = '0;
  logic       flush = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;
  int         seq = 0;
  logic [31:0] last_pld;
  logic [36:0] exp_q[$];
  icache_tag_req_arbiter_if #(.PLD_WIDTH(32), .IDX_WIDTH(3)) bus ();
  icache_tag_req_arbiter #(.MSHR_ENTRY_NUM(8), .MSHR_ENTRY_INDEX_WIDTH(3), .PF_STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .v_mshr_entry_array_valid(valid), .flush(flush)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // g selects the expected grant: -1 none, 0 fetch, 1 prefetch, 2 snoop
  task automatic step(input string name, input logic f, input logic p, input logic s, input int g, input logic [2:0] idx);
    logic [31:0] pld;
    seq++;
    bus.fetch_req_vld = f;
    bus.pf_req_vld    = p;
    bus.snp_req_vld   = s;
    bus.fetch_req_pld = {8'hA0, seq[23:0]};
    bus.pf_req_pld    = {8'hB0, seq[23:0]};
    bus.snp_req_pld   = {8'hC0, seq[23:0]};
    @(negedge clk);
    check(name, {61'd0, bus.snp_req_rdy, bus.pf_req_rdy, bus.fetch_req_rdy}, (g < 0) ? 64'd0 : 64'd1 << g);
    if (g >= 0) begin
      pld = (g == 0) ? bus.fetch_req_pld : (g == 1) ? bus.pf_req_pld : bus.snp_req_pld;
      last_pld = pld;
      exp_q.push_back({2'(g), idx, pld});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic release_all();
    valid = 8'hFF;
    step("release", 1'b0, 1'b0, 1'b0, -1, 3'd0);
    valid = 8'h00;
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.tag_req_vld && bus.tag_req_rdy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tag_out: got %0h expected no request", {bus.tag_req_src, bus.tag_req_index, bus.tag_req_pld});
      end else
        check("tag_out", {27'd0, bus.tag_req_src, bus.tag_req_index, bus.tag_req_pld}, {27'd0, exp_q.pop_front()});
    end
  end
  initial begin
    logic [31:0] held;
    bus.fetch_req_vld = 1'b0;
    bus.pf_req_vld    = 1'b0;
    bus.snp_req_vld   = 1'b0;
    bus.fetch_req_pld = '0;
    bus.pf_req_pld    = '0;
    bus.snp_req_pld   = '0;
    bus.tag_req_rdy   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld", {63'd0, bus.tag_req_vld}, 64'd0);
    check("rst_out", {27'd0, bus.tag_req_src, bus.tag_req_index, bus.tag_req_pld}, 64'd0);
    check("rst_rdy", {61'd0, bus.snp_req_rdy, bus.pf_req_rdy, bus.fetch_req_rdy}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.tag_req_rdy = 1'b1;
    step("arb_snp", 1'b1, 1'b1, 1'b1, 2, 3'd0);
    step("arb_fetch", 1'b1, 1'b1, 1'b0, 0, 3'd0);
    step("arb_pf", 1'b0, 1'b1, 1'b0, 1, 3'd1);
    step("arb_idle", 1'b0, 1'b0, 1'b0, -1, 3'd0);
    release_all();
    step("hold_grant", 1'b1, 1'b0, 1'b0, 0, 3'd0);
    held = last_pld;
    bus.tag_req_rdy = 1'b0;
    repeat (3) begin
      step("hold_block", 1'b1, 1'b0, 1'b0, -1, 3'd0);
      check("hold_vld", {63'd0, bus.tag_req_vld}, 64'd1);
      check("hold_out", {27'd0, bus.tag_req_src, bus.tag_req_index, bus.tag_req_pld}, {27'd0, 2'd0, 3'd0, held});
    end
    bus.tag_req_rdy = 1'b1;
    step("hold_resume", 1'b1, 1'b0, 1'b0, 0, 3'd1);
    check("b2b_vld", {63'd0, bus.tag_req_vld}, 64'd1);
    step("hold_drain", 1'b0, 1'b0, 1'b0, -1, 3'd0);
    release_all();
    valid = 8'hFF;
    step("full_snp", 1'b1, 1'b0, 1'b1, 2, 3'd0);
    step("full_fetch", 1'b1, 1'b0, 1'b0, -1, 3'd0);
    valid = 8'hDF;
    step("full_free5", 1'b1, 1'b0, 1'b0, 0, 3'd5);
    valid = 8'hFF;
    step("full_drain", 1'b0, 1'b0, 1'b0, -1, 3'd0);
    valid = 8'h00;
    step("res_0", 1'b1, 1'b0, 1'b0, 0, 3'd0);
    step("res_1", 1'b1, 1'b0, 1'b0, 0, 3'd1);
    step("res_2", 1'b1, 1'b0, 1'b0, 0, 3'd2);
    step("res_wait", 1'b0, 1'b0, 1'b0, -1, 3'd0);
    step("res_wait", 1'b0, 1'b0, 1'b0, -1, 3'd0);
    step("res_3", 1'b1, 1'b0, 1'b0, 0, 3'd3);
    valid = 8'h04;
    step("res_clr2", 1'b0, 1'b0, 1'b0, -1, 3'd0);
    valid = 8'h00;
    step("res_again2", 1'b1, 1'b0, 1'b0, 0, 3'd2);
    release_all();
    // MSHR model: each granted entry turns valid for the following cycle only
    for (int k = 0; k < 10; k++) begin
      valid = (k == 0) ? 8'h00 : 8'(1 << ((k - 1) % 2));
      step("starve", 1'b1, 1'b1, 1'b0, (k % 5 == 4) ? 1 : 0, 3'(k % 2));
    end
    valid = 8'h00;
    step("starve_drain", 1'b0, 1'b0, 1'b0, -1, 3'd0);
    release_all();
    step("fl_pre0", 1'b1, 1'b0, 1'b0, 0, 3'd0);
    step("fl_pre1", 1'b1, 1'b0, 1'b0, 0, 3'd1);
    bus.tag_req_rdy = 1'b0;
    flush = 1'b1;
    step("fl_block", 1'b1, 1'b0, 1'b0, -1, 3'd0);
    flush = 1'b0;
    void'(exp_q.pop_back());
    check("fl_vld", {63'd0, bus.tag_req_vld}, 64'd0);
    bus.tag_req_rdy = 1'b1;
    step("fl_realloc", 1'b1, 1'b0, 1'b0, 0, 3'd0);
    step("fl_drain", 1'b0, 1'b0, 1'b0, -1, 3'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
